board_position_ctrl: RTL

//  Board-side controller for the chicken race: holds every player's tile position and tail count,

---
 rtl/board_position_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/board_position_ctrl.sv
// Chicken-race board controller: player positions, tail counts, turn order and winner detection.
// Optional build macro TURN_TIMEOUT_EN forfeits a turn after TIMEOUT_CYC idle cycles in WAIT_FLIP.
module board_position_ctrl #(
  parameter int NUM_TILES   = 24,
  parameter int NUM_IMAGES  = 12,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  N,
  input  logic        go_valid,
  input  logic        go,
  output logic [3:0]  position_data,
  output logic [4:0]  tile_info,
  output logic [1:0]  turn,
  output logic        next_turn,
  output logic [11:0] tails,
  output logic        W,
  output logic [1:0]  winner,
  output logic        busy
);

  if (NUM_TILES > 32 || NUM_TILES % 4 != 0 || NUM_IMAGES > 16 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("board_position_ctrl: unsupported parameter combination");
  end

  localparam int QUARTER = NUM_TILES / 4;

  typedef enum logic [2:0] {
    IDLE, SETUP, WAIT_FLIP, MOVE, CAPTURE, NEXT, WIN
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  pos      [4];
  logic [2:0]  tail_cnt [4];
  logic [1:0]  last_player;  // player count minus one, latched at start
  logic [4:0]  cur_pos;
  logic [4:0]  ahead;
  logic [2:0]  gain;
  logic [3:0]  victims;
  logic        win_now;
  logic        timeout;

  assign cur_pos       = pos[turn];
  assign ahead         = (cur_pos == 5'(NUM_TILES - 1)) ? 5'd0 : cur_pos + 5'd1;
  assign position_data = 4'(int'(ahead) % NUM_IMAGES);
  assign tile_info     = cur_pos;
  assign next_turn     = (state == NEXT);
  assign W             = (state == WIN);
  assign busy          = (state == MOVE) || (state == CAPTURE) || (state == NEXT);

  always_comb begin
    tails = '0;
    for (int i = 0; i < 4; i++) tails[3*i +: 3] = tail_cnt[i];
  end

  // Tails the current player would hold after sweeping everyone sharing its tile.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gain    = tail_cnt[turn];
    victims = '0;
    for (int j = 0; j < 4; j++) begin
      if (2'(j) != turn && 2'(j) <= last_player && pos[j] == cur_pos) begin
        victims[j] = 1'b1;
        gain       = gain + tail_cnt[j];
      end
    end
  end

  assign win_now = (gain == ({1'b0, last_player} + 3'd1));

`ifdef TURN_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC) > 10) ? $clog2(TIMEOUT_CYC) : 10;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_FLIP) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_FLIP) && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = SETUP;
      SETUP:     state_nxt = WAIT_FLIP;
      WAIT_FLIP: begin
        if (go_valid)     state_nxt = go ? MOVE : NEXT;
        else if (timeout) state_nxt = NEXT;
      end
      MOVE:      state_nxt = CAPTURE;
      CAPTURE:   state_nxt = win_now ? WIN : WAIT_FLIP;
      NEXT:      state_nxt = WAIT_FLIP;
      WIN:       if (start) state_nxt = SETUP;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      turn        <= '0;
      winner      <= '0;
      last_player <= '0;
      // NOTE: the position/tail arrays are tiny flop banks with a defined reset value, not RAM.
      for (int i = 0; i < 4; i++) begin
        pos[i]      <= '0;
        tail_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, WIN: if (start) last_player <= (N == 2'd0) ? 2'd1 : N;
        SETUP: begin
          turn <= '0;
          for (int i = 0; i < 4; i++) begin
            pos[i]      <= 5'(i * QUARTER);
            tail_cnt[i] <= (2'(i) <= last_player) ? 3'd1 : 3'd0;
          end
        end
        MOVE:    pos[turn] <= ahead;
        CAPTURE: begin
          for (int j = 0; j < 4; j++) begin
            if (victims[j]) tail_cnt[j] <= '0;
          end
          tail_cnt[turn] <= gain;
          if (win_now) winner <= turn;
        end
        NEXT:    turn <= (turn == last_player) ? 2'd0 : turn + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
